// File: rtl/phase_timer_pkg.sv
// phase_timer_pkg: shared state encoding, default sizes and duration-bus helper
// for the multi-phase timer.
package phase_timer_pkg;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} phase_timer_state_e;

    localparam int DEF_WIDTH      = 11;
    localparam int DEF_NUM_PHASES = 4;
    localparam int MAX_BUS_W      = 1024;

    // Returns the w-bit field idx of a packed bus, zero-extended to 32 bits.
    function automatic logic [31:0] dur_at(input logic [MAX_BUS_W-1:0] bus,
                                           input int unsigned idx,
                                           input int unsigned w);
        logic [MAX_BUS_W-1:0] sh;
        sh = bus >> (idx * w);
        return sh[31:0] & ((w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1));
    endfunction

endpackage

// File: rtl/phase_timer_interval_counter.sv
// interval_counter: WIDTH-bit up-counter that wraps to zero on reaching its
// terminal value, with a registered terminal pulse.
module interval_counter #(
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_zero,
    input  logic             enable,
    input  logic [WIDTH-1:0] terminal,
    output logic [WIDTH-1:0] count,
    output logic             at_term,
    output logic             tc_pulse
);

    logic [WIDTH-1:0] r_count;
    logic             r_tc;

    assign at_term  = r_count == terminal;
    assign count    = r_count;
    assign tc_pulse = r_tc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_tc    <= 1'b0;
        end else begin
            r_tc    <= enable && !load_zero && at_term;
            r_count <= load_zero ? '0 : !enable ? r_count : at_term ? '0 : r_count + 1'b1;
        end
    end

endmodule

// File: rtl/phase_timer.sv
// phase_timer: steps through NUM_PHASES programmable durations, pulsing at
// every phase end and at the end of each full sequence.
module phase_timer
    import phase_timer_pkg::*;
#(
    parameter  int WIDTH      = DEF_WIDTH,
    parameter  int NUM_PHASES = DEF_NUM_PHASES,
    localparam int PHASE_W    = $clog2(NUM_PHASES)
) (
    input  logic                        clk,
    input  logic                        resetN,
    input  logic                        start,
    input  logic                        hold,
    input  logic                        one_shot,
    input  logic [NUM_PHASES*WIDTH-1:0] durations,
    output logic [PHASE_W-1:0]          phase,
    output logic [WIDTH-1:0]            count,
    output logic                        phase_done,
    output logic                        cycle_done,
    output logic                        busy
);

    localparam logic [PHASE_W-1:0] LAST = PHASE_W'(NUM_PHASES - 1);

    phase_timer_state_e r_state, w_next;
    logic [PHASE_W-1:0] r_phase, w_next_phase;
    logic [WIDTH-1:0]   r_dur, w_count;
    logic               r_cycle_done;
    logic               w_active, w_step, w_at_term, w_end, w_last, w_finish, w_phase_done;

    // hold is checked ahead of the terminal compare so a held terminal cycle defers the phase end
    assign w_active     = (r_state == RUN) || (r_state == PAUSE);
    assign w_step       = w_active && !hold && !start;
    assign w_end        = w_step && w_at_term;
    assign w_last       = r_phase == LAST;
    assign w_finish     = w_end && w_last && one_shot;
    assign w_next_phase = w_last ? '0 : r_phase + 1'b1;

    interval_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk      (clk),
        .rst      (resetN),
        .load_zero(start),
        .enable   (w_step),
        .terminal (r_dur),
        .count    (w_count),
        .at_term  (w_at_term),
        .tc_pulse (w_phase_done)
    );

    always_ff @(posedge clk or posedge resetN) begin
        if (resetN) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = start ? RUN : !w_active ? r_state : hold ? PAUSE : w_finish ? DONE : RUN;
    end

    // A one-shot finish leaves phase on the last index and keeps the latch as is
    always_ff @(posedge clk or posedge resetN) begin
        if (resetN) begin
            r_phase      <= '0;
            r_dur        <= '0;
            r_cycle_done <= 1'b0;
        end else begin
            r_cycle_done <= w_end && w_last;
            if (start) begin
                r_phase <= '0;
                r_dur   <= WIDTH'(dur_at(MAX_BUS_W'(durations), 0, WIDTH));
            end else if (w_end && !w_finish) begin
                r_phase <= w_next_phase;
                r_dur   <= WIDTH'(dur_at(MAX_BUS_W'(durations), 32'(w_next_phase), WIDTH));
            end
        end
    end

    assign phase      = r_phase;
    assign count      = w_count;
    assign phase_done = w_phase_done;
    assign cycle_done = r_cycle_done;
    assign busy       = w_active;

endmodule

// File: tb/tb_phase_timer.sv
// tb_phase_timer: table-driven vectors, directed corner sequences and a
// randomized run against a behavioural model of the phase timer.
module tb_phase_timer;

    localparam int W  = 11;
    localparam int NP = 4;

    logic              clk, resetN, start, hold, one_shot;
    logic [NP*W-1:0]   durations;
    logic [1:0]        phase;
    logic [W-1:0]      count;
    logic              phase_done, cycle_done, busy;

    int n_err = 0;
    int n_chk = 0;

    phase_timer #(.WIDTH(W), .NUM_PHASES(NP)) dut (
        .clk       (clk),
        .resetN    (resetN),
        .start     (start),
        .hold      (hold),
        .one_shot  (one_shot),
        .durations (durations),
        .phase     (phase),
        .count     (count),
        .phase_done(phase_done),
        .cycle_done(cycle_done),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int st, hd, os;
        int e_ph, e_cnt, e_pd, e_cd, e_busy;
    } vec_t;
    vec_t tbl[$];

    int  m_ph, m_cnt, m_lat;
    bit  m_active, m_pd, m_cd;

    function automatic logic [NP*W-1:0] pack4(int d0, int d1, int d2, int d3);
        pack4 = {W'(d3), W'(d2), W'(d1), W'(d0)};
    endfunction

    function automatic int mdur(logic [NP*W-1:0] d, int i);
        logic [NP*W-1:0] s;
        s = d >> (i * W);
        return int'(s[W-1:0]);
    endfunction

    task automatic chk(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(string tag, int e_ph, int e_cnt, int e_pd, int e_cd, int e_busy);
        chk({tag, ".phase"}, int'(phase), e_ph);
        chk({tag, ".count"}, int'(count), e_cnt);
        chk({tag, ".phase_done"}, int'(phase_done), e_pd);
        chk({tag, ".cycle_done"}, int'(cycle_done), e_cd);
        chk({tag, ".busy"}, int'(busy), e_busy);
    endtask

    task automatic model_reset();
        m_ph = 0; m_cnt = 0; m_lat = 0; m_active = 0; m_pd = 0; m_cd = 0;
    endtask

    // One clock of sequence behaviour: a phase lasts lat+1 active cycles, pulses
    // accompany the cycle after the last one, and one-shot parks on the last phase.
    task automatic model_step(bit st, bit hd, bit os, logic [NP*W-1:0] d);
        m_pd = 0;
        m_cd = 0;
        if (st) begin
            m_ph = 0; m_cnt = 0; m_lat = mdur(d, 0); m_active = 1;
        end else if (m_active && !hd) begin
            if (m_cnt < m_lat) m_cnt++;
            else begin
                m_pd  = 1;
                m_cnt = 0;
                if (m_ph == NP - 1) begin
                    m_cd = 1;
                    if (os) m_active = 0;
                    else m_ph = 0;
                end else m_ph++;
                if (m_active) m_lat = mdur(d, m_ph);
            end
        end
    endtask

    initial begin
        int n, tot;
        resetN = 1'b1; start = 0; hold = 0; one_shot = 0;
        durations = pack4(3, 1, 0, 2);
        repeat (2) step();
        chk_all("reset", 0, 0, 0, 0, 0);
        resetN = 1'b0;
        step();
        chk_all("idle", 0, 0, 0, 0, 0);

        tbl.push_back('{1,0,0, 0,0,0,0,1});
        tbl.push_back('{0,0,0, 0,1,0,0,1});
        tbl.push_back('{0,0,0, 0,2,0,0,1});
        tbl.push_back('{0,0,0, 0,3,0,0,1});
        tbl.push_back('{0,0,0, 1,0,1,0,1});
        tbl.push_back('{0,0,0, 1,1,0,0,1});
        tbl.push_back('{0,0,0, 2,0,1,0,1});
        tbl.push_back('{0,0,0, 3,0,1,0,1});
        tbl.push_back('{0,0,0, 3,1,0,0,1});
        tbl.push_back('{0,0,0, 3,2,0,0,1});
        tbl.push_back('{0,0,0, 0,0,1,1,1});
        tbl.push_back('{0,0,0, 0,1,0,0,1});
        tbl.push_back('{1,0,1, 0,0,0,0,1});
        tbl.push_back('{0,0,1, 0,1,0,0,1});
        tbl.push_back('{0,0,1, 0,2,0,0,1});
        tbl.push_back('{0,0,1, 0,3,0,0,1});
        tbl.push_back('{0,0,1, 1,0,1,0,1});
        tbl.push_back('{0,0,1, 1,1,0,0,1});
        tbl.push_back('{0,0,1, 2,0,1,0,1});
        tbl.push_back('{0,0,1, 3,0,1,0,1});
        tbl.push_back('{0,0,1, 3,1,0,0,1});
        tbl.push_back('{0,0,1, 3,2,0,0,1});
        tbl.push_back('{0,0,1, 3,0,1,1,0});
        tbl.push_back('{0,0,1, 3,0,0,0,0});
        tbl.push_back('{0,1,1, 3,0,0,0,0});
        tbl.push_back('{0,0,0, 3,0,0,0,0});
        tbl.push_back('{1,0,1, 0,0,0,0,1});
        tbl.push_back('{0,0,1, 0,1,0,0,1});
        tbl.push_back('{1,1,0, 0,0,0,0,1});
        tbl.push_back('{0,1,0, 0,0,0,0,1});
        tbl.push_back('{0,0,0, 0,1,0,0,1});

        foreach (tbl[i]) begin
            start = 1'(tbl[i].st); hold = 1'(tbl[i].hd); one_shot = 1'(tbl[i].os);
            step();
            chk_all($sformatf("vec%0d", i), tbl[i].e_ph, tbl[i].e_cnt, tbl[i].e_pd, tbl[i].e_cd, tbl[i].e_busy);
        end
        start = 0; hold = 0; one_shot = 0;

        // hold on count=2 of phase 0 for 5 cycles delays the phase end by exactly 5
        start = 1; step(); start = 0;
        step(); step();
        chk("hold.pre_count", int'(count), 2);
        hold = 1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk_all($sformatf("hold%0d", k), 0, 2, 0, 0, 1);
        end
        hold = 0;
        n = 0;
        do begin step(); n++; end while (!phase_done && n < 20);
        tot = 2 + 5 + n;
        chk("hold.pd_edge", tot, 9);
        chk("hold.phase_after", int'(phase), 1);

        // duration change mid-phase applies only from the next sequence
        start = 1; step(); start = 0;
        repeat (4) step();
        chk("dchg.in_ph1", int'(phase), 1);
        durations = pack4(3, 7, 0, 2);
        step(); step();
        chk("dchg.old_len_phase", int'(phase), 2);
        chk("dchg.old_len_pd", int'(phase_done), 1);
        n = 0;
        do begin step(); n++; end while (phase != 2'd1 && n < 30);
        chk("dchg.reach_ph1", int'(phase), 1);
        n = 0;
        do begin step(); n++; end while (phase == 2'd1 && n < 30);
        chk("dchg.new_len", n, 8);
        durations = pack4(3, 1, 2, 2);

        // start at count=1 of phase 2 restarts with no pulse
        start = 1; step(); start = 0;
        n = 0;
        while (!(phase == 2'd2 && count == W'(1)) && n < 40) begin step(); n++; end
        chk("restart.reach", int'(count) + 10 * int'(phase), 21);
        start = 1; step(); start = 0;
        chk_all("restart", 0, 0, 0, 0, 1);

        // async reset mid-phase while paused
        step(); step();
        hold = 1; step();
        chk("rst.pre_count", int'(count), 2);
        #2 resetN = 1'b1;
        #1 chk_all("rst.async", 0, 0, 0, 0, 0);
        #2 resetN = 1'b0;
        hold = 0;
        repeat (3) step();
        chk_all("rst.idle", 0, 0, 0, 0, 0);

        // randomized run against the model
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            start    = ($urandom_range(0, 29) == 0);
            hold     = ($urandom_range(0, 5) == 0);
            one_shot = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0)
                durations[$urandom_range(0, NP-1) * W +: W] = W'($urandom_range(0, 6));
            model_step(start, hold, one_shot, durations);
            step();
            chk_all($sformatf("rnd%0d", c), m_ph, m_cnt, int'(m_pd), int'(m_cd), int'(m_active));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/phase_timer.md
Name: phase_timer

Overview:
Parametrised successor to the single-interval counter. It steps through NUM_PHASES programmable phase durations in order, pulsing on every phase end and every full-sequence end. It supports start, pause, periodic/one-shot mode and per-phase duration latching. It sits between the traffic-light controller FSM and the light decoder, supplying the current phase index and timing pulses.

Parameters:
WIDTH, 11, bit width of duration and count values
NUM_PHASES, 4, number of phases in one sequence (>=2)
PHASE_W, $clog2(NUM_PHASES), width of phase index (derived, not overridden)

Ports:
clk  input  1  system clock, all logic on rising edge
resetN  input  1  asynchronous, active-high reset (despite the N suffix; asserted = 1)
start  input  1  pulse: (re)start sequence from phase 0
hold  input  1  level: freeze count/phase while high
one_shot  input  1  1 = stop after last phase; 0 = wrap to phase 0 and continue
durations  input  NUM_PHASES*WIDTH  packed per-phase terminal counts, phase i at [i*WIDTH +: WIDTH]
phase  output  PHASE_W  current phase index
count  output  WIDTH  cycles elapsed in current phase
phase_done  output  1  one-cycle pulse on the last cycle of each phase
cycle_done  output  1  one-cycle pulse on the last cycle of the last phase
busy  output  1  high in RUN or PAUSE

Behaviour:
- Reset (async, resetN=1): state=IDLE; phase=0, count=0, phase_done=0, cycle_done=0, busy=0, latched duration=0.
- States: IDLE, RUN, PAUSE, DONE.
- IDLE: outputs hold reset values. start=1 -> RUN next cycle, phase=0, count=0, durations[0] latched.
- RUN, per cycle:
  - count < dur_lat: count+1.
  - count == dur_lat: phase ends. phase_done=1 that cycle (registered, visible the next edge, same timing as legacy overflow). count<=0. phase<=phase+1. durations[next] latched.
- Phase length = dur_lat+1 cycles. Duration 0 = one-cycle phase (never stalls, unlike the legacy max_count=0 case).
- Last phase end (phase==NUM_PHASES-1): cycle_done=1 together with phase_done.
  - one_shot=0: phase<=0, stay RUN.
  - one_shot=1: -> DONE, phase and count hold their final values (phase=NUM_PHASES-1, count=0).
- Durations are latched on phase entry only. Changing the durations input mid-phase has no effect until the next phase.
- hold=1 in RUN -> PAUSE. count, phase and latched duration are frozen; no pulses. hold=0 -> back to RUN, resuming the same count.
- hold is sampled before the terminal check: if hold=1 on a terminal cycle, the phase end is deferred until release.
- start=1 in any state except reset: restart at phase 0, count=0, RUN, durations[0] re-latched. start has priority over hold and over the terminal transition. No pulse is emitted that cycle.
- DONE: busy=0; pulses 0. start -> RUN as above. Otherwise stays in DONE.
- one_shot is sampled only at the last-phase end.
- Arithmetic is unsigned WIDTH-bit. count never exceeds dur_lat, so no wrap occurs inside a phase. phase increments modulo NUM_PHASES.
- Reset asserted mid-operation: immediate async return to reset values. After release, the block idles until start.

Decomposition:
- Package phase_timer_pkg:
  - state enum phase_timer_state_e (IDLE, RUN, PAUSE, DONE)
  - default WIDTH/NUM_PHASES localparams
  - function extracting duration i from the packed bus
- Sub-module interval_counter:
  - WIDTH-bit count with load_zero, enable, terminal-value input
  - registered terminal pulse
  - generalises the legacy counter
- The top level holds the FSM, the phase register and the duration latch.

Test Plan:
- Reset then start, durations={3,1,0,2} (phase0..3), one_shot=0 -> phase lengths 4,2,1,3 cycles; phase_done at end of each; cycle_done after 10 cycles; phase wraps to 0.
- Same durations, one_shot=1 -> after cycle_done, DONE: busy=0, phase=3, no further pulses; second start reruns identically.
- hold high for 5 cycles at count=2 in phase0 (dur 3) -> count stays 2, no pulses; after release, phase_done arrives exactly 5 cycles later than nominal.
- Change durations[1] from 1 to 7 while in phase1 -> current phase still 2 cycles; the new value applies on the next sequence.
- start asserted while count=1 in phase2 -> next cycle phase=0, count=0, no phase_done that cycle.
- resetN pulsed mid-phase with hold=1 -> all outputs 0 immediately; after release the block stays IDLE until start.
